// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control path:
// FSM state enum, opcode values, datapath mux-select encodings and the
// packed control bundle that the output decoder produces from the state.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Opcode field values
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore control bundle; pc_write/branch are combined into pc_en by the top
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Output decoder: maps the FSM state to the datapath control bundle.
// Ports: state_i (current, reset-adjusted state) -> ctrl_o (selects/enables).
// Purely combinational; anything not listed for a state is driven 0.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                // Both are further qualified by mem_ready in the top
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut
                ctrl_o.alu_src_b = SRCB_IMMSH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = PCSRC_ALUOUT;
                ctrl_o.branch    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Main control FSM of the multicycle MIPS core plus retired-instruction counter.
// Ports: clk/reset_n (sync, active-low), op/zero/mem_ready in; datapath
// selects, write enables, illegal_op pulse and instr_retired count out.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_retired
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             illegal_dec;
    state_t           dec_state;
    ctrl_t            ctrl;
    logic             mem_gate;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        illegal_dec = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // While reset is held the state register may not have reached FETCH
    // yet, so decode as FETCH directly to present FETCH selects at once.
    assign dec_state = reset_n ? state_q : S_FETCH;

    mips_mc_outdec u_outdec (
        .state_i (dec_state),
        .ctrl_o  (ctrl)
    );

    // Only the FETCH enables wait on memory; JUMP's PC write is unconditional.
    assign mem_gate = (dec_state != S_FETCH) | mem_ready;

    assign IorD          = ctrl.iord;
    assign RegDst        = ctrl.reg_dst;
    assign MemtoReg      = ctrl.mem_to_reg;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign ALUOp         = ctrl.alu_op;
    assign PCSrc         = ctrl.pc_src;
    assign IRWrite       = reset_n & ctrl.ir_write & mem_gate;
    assign MemWrite      = reset_n & ctrl.mem_write;
    assign RegWrite      = reset_n & ctrl.reg_write;
    assign pc_en         = reset_n & ((ctrl.pc_write & mem_gate) | (ctrl.branch & zero));
    assign illegal_op    = reset_n & illegal_dec;
    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Testbench for mips_mc_ctrl: directed per-cycle vectors with hand-written
// expected control words pushed to a scoreboard; a negedge monitor compares.
// Inputs are driven #1 after the rising edge.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  op = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
    logic        pc_en, illegal_op;
    logic [31:0] instr_retired;

    mips_mc_ctrl #(.CNT_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .IorD          (IorD),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .PCSrc         (PCSrc),
        .pc_en         (pc_en),
        .illegal_op    (illegal_op),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    // Control word layout:
    // {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
    //  ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], pc_en, illegal_op}
    localparam logic [14:0] E_IDLE   = {7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0}; // FETCH, reset or stalled
    localparam logic [14:0] E_FETCH  = {7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [14:0] E_DECODE = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_DECILL = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [14:0] E_MEMADR = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMRD  = {7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMWB  = {7'b0000110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMWR  = {7'b1100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_EXEC   = {7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_ALUWB  = {7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_BR_T   = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [14:0] E_BR_N   = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
    localparam logic [14:0] E_ADDIEX = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_ADDIWB = {7'b0000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_JUMP   = {7'b0000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};

    typedef struct packed {
        logic [14:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // One clock cycle of stimulus plus the outputs expected during it
    task automatic step(input logic rst, input logic [5:0] o, input logic z,
                        input logic rdy, input logic [14:0] ectl,
                        input logic [31:0] ecnt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = rst;
        op        = o;
        zero      = z;
        mem_ready = rdy;
        e.ctl = ectl;
        e.cnt = ecnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are Moore/combinational, so every cycle presents a response
    initial begin
        exp_t        e;
        string       nm;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                       ALUSrcB, ALUOp, PCSrc, pc_en, illegal_op};
                n_checks++;
                if (act !== e.ctl) begin
                    n_errors++;
                    $display("FAIL %s ctl: got %b expected %b", nm, act, e.ctl);
                end
                n_checks++;
                if (instr_retired !== e.cnt) begin
                    n_errors++;
                    $display("FAIL %s count: got %0d expected %0d", nm, instr_retired, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for three edges with mem_ready high
        for (int i = 0; i < 3; i++) step(1'b0, 6'h00, 1'b0, 1'b1, E_IDLE, 0, "reset");

        // lw: 5 cycles
        step(1'b1, 6'h23, 1'b0, 1'b1, E_FETCH,  0, "lw_fetch");
        step(1'b1, 6'h23, 1'b0, 1'b1, E_DECODE, 0, "lw_decode");
        step(1'b1, 6'h23, 1'b0, 1'b1, E_MEMADR, 0, "lw_memadr");
        step(1'b1, 6'h23, 1'b0, 1'b1, E_MEMRD,  0, "lw_memrd");
        step(1'b1, 6'h23, 1'b0, 1'b1, E_MEMWB,  0, "lw_memwb");

        // sw with two wait cycles in MEMWR: 6 cycles
        step(1'b1, 6'h2B, 1'b0, 1'b1, E_FETCH,  1, "sw_fetch");
        step(1'b1, 6'h2B, 1'b0, 1'b1, E_DECODE, 1, "sw_decode");
        step(1'b1, 6'h2B, 1'b0, 1'b1, E_MEMADR, 1, "sw_memadr");
        step(1'b1, 6'h2B, 1'b0, 1'b0, E_MEMWR,  1, "sw_wait1");
        step(1'b1, 6'h2B, 1'b0, 1'b0, E_MEMWR,  1, "sw_wait2");
        step(1'b1, 6'h2B, 1'b0, 1'b1, E_MEMWR,  1, "sw_done");

        // R-type
        step(1'b1, 6'h00, 1'b0, 1'b1, E_FETCH,  2, "r_fetch");
        step(1'b1, 6'h00, 1'b0, 1'b1, E_DECODE, 2, "r_decode");
        step(1'b1, 6'h00, 1'b0, 1'b1, E_EXEC,   2, "r_exec");
        step(1'b1, 6'h00, 1'b0, 1'b1, E_ALUWB,  2, "r_aluwb");

        // beq taken
        step(1'b1, 6'h04, 1'b0, 1'b1, E_FETCH,  3, "beqt_fetch");
        step(1'b1, 6'h04, 1'b0, 1'b1, E_DECODE, 3, "beqt_decode");
        step(1'b1, 6'h04, 1'b1, 1'b1, E_BR_T,   3, "beqt_branch");

        // beq not taken
        step(1'b1, 6'h04, 1'b0, 1'b1, E_FETCH,  4, "beqn_fetch");
        step(1'b1, 6'h04, 1'b0, 1'b1, E_DECODE, 4, "beqn_decode");
        step(1'b1, 6'h04, 1'b0, 1'b1, E_BR_N,   4, "beqn_branch");

        // addi
        step(1'b1, 6'h08, 1'b0, 1'b1, E_FETCH,  5, "addi_fetch");
        step(1'b1, 6'h08, 1'b0, 1'b1, E_DECODE, 5, "addi_decode");
        step(1'b1, 6'h08, 1'b0, 1'b1, E_ADDIEX, 5, "addi_ex");
        step(1'b1, 6'h08, 1'b0, 1'b1, E_ADDIWB, 5, "addi_wb");

        // j
        step(1'b1, 6'h02, 1'b0, 1'b1, E_FETCH,  6, "j_fetch");
        step(1'b1, 6'h02, 1'b0, 1'b1, E_DECODE, 6, "j_decode");
        step(1'b1, 6'h02, 1'b0, 1'b1, E_JUMP,   6, "j_jump");

        // Unsupported opcode: illegal pulse, no retire
        step(1'b1, 6'h3F, 1'b0, 1'b1, E_FETCH,  7, "ill_fetch");
        step(1'b1, 6'h3F, 1'b0, 1'b1, E_DECILL, 7, "ill_decode");

        // Fetch stall, then R-type abandoned by reset in EXEC
        step(1'b1, 6'h00, 1'b0, 1'b0, E_IDLE,   7, "fetch_stall");
        step(1'b1, 6'h00, 1'b0, 1'b1, E_FETCH,  7, "rst_r_fetch");
        step(1'b1, 6'h00, 1'b0, 1'b1, E_DECODE, 7, "rst_r_decode");
        step(1'b0, 6'h00, 1'b0, 1'b1, E_IDLE,   7, "rst_in_exec");
        step(1'b1, 6'h02, 1'b0, 1'b1, E_FETCH,  0, "post_rst_fetch");
        step(1'b1, 6'h02, 1'b0, 1'b1, E_DECODE, 0, "post_rst_decode");
        step(1'b1, 6'h02, 1'b0, 1'b1, E_JUMP,   0, "post_rst_jump");
        step(1'b1, 6'h00, 1'b0, 1'b0, E_IDLE,   1, "post_rst_count");

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
